// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: round-robin arbiter sharing one registered rotate unit among NREQ requesters
module barrel_shift_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ = 4,
  localparam int SW = $clog2(WIDTH),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*SW-1:0]   req_amt,
  input  logic [NREQ-1:0]      req_dir,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [IW-1:0]        rsp_id
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, gnt_idx, idx;
  logic gnt_any, acc;
  logic [WIDTH-1:0] d, rot;
  logic [SW-1:0] amt;
  logic [2*WIDTH-1:0] dd;
  // round-robin search from ptr; scanning farthest-first lets the nearest valid requester win
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  // rotate the granted operand through a doubled word so both directions are a single shift
  always_comb begin
    d = req_data[gnt_idx*WIDTH +: WIDTH];
    amt = req_amt[gnt_idx*SW +: SW];
    dd = req_dir[gnt_idx] ? ({d, d} << amt) : ({d, d} >> amt);
    rot = req_dir[gnt_idx] ? dd[2*WIDTH-1:WIDTH] : dd[WIDTH-1:0];
  end
  // acceptance only in IDLE and never while reset is held
  always_comb begin
    acc = !rst && state == IDLE && gnt_any;
    req_ready = acc ? (NREQ'(1) << gnt_idx) : '0;
    state_nxt = acc ? BUSY : (state == BUSY && rsp_ready) ? IDLE : state;
  end
  assign rsp_valid = state == BUSY;
  // state, pointer and held result; the result only changes on acceptance so it holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        rsp_data <= rot;
        rsp_id <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_barrel_shift_arb.sv
// tb_barrel_shift_arb: directed vector table plus arbitration sequences for barrel_shift_arb
module tb_barrel_shift_arb;
  localparam int WIDTH = 16;
  localparam int NREQ = 4;
  localparam int SW = 4;
  localparam int IW = 2;
  logic clk = 0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, req_dir;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*SW-1:0] req_amt;
  logic rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  int errors = 0;
  int checks = 0;
  typedef struct {
    int id;
    logic [15:0] data;
    logic [3:0] amt;
    logic dir;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[11];
  logic [15:0] held_data;
  logic [1:0] held_id;

  barrel_shift_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1 chk("ready_in_rst", 32'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_ptr", 32'(dut.ptr), 0);
    rst = 0;
  endtask

  task automatic run_vec(input vec_t v);
    req_valid = '0;
    req_data = {NREQ{16'h5A5A}};
    req_amt = {NREQ{4'd3}};
    req_dir = ~(NREQ'(1) << v.id);
    req_valid[v.id] = 1'b1;
    req_data[v.id*WIDTH +: WIDTH] = v.data;
    req_amt[v.id*SW +: SW] = v.amt;
    req_dir[v.id] = v.dir;
    #1 chk("vec_ready", 32'(req_ready), 32'(1) << v.id);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("vec_rsp_valid", 32'(rsp_valid), 1);
    chk("vec_rsp_data", 32'(rsp_data), 32'(v.exp));
    chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("vec_idle", 32'(rsp_valid), 0);
  endtask

  initial begin
    vecs[0]  = '{0, 16'hF04F, 4'd5,  1'b0, 16'h7F82};
    vecs[1]  = '{0, 16'hF04F, 4'd5,  1'b1, 16'h09FE};
    vecs[2]  = '{1, 16'hF04F, 4'd0,  1'b0, 16'hF04F};
    vecs[3]  = '{2, 16'hF04F, 4'd0,  1'b1, 16'hF04F};
    vecs[4]  = '{3, 16'h0001, 4'd1,  1'b0, 16'h8000};
    vecs[5]  = '{3, 16'h8000, 4'd1,  1'b1, 16'h0001};
    vecs[6]  = '{1, 16'h1234, 4'd4,  1'b1, 16'h2341};
    vecs[7]  = '{2, 16'h1234, 4'd4,  1'b0, 16'h4123};
    vecs[8]  = '{0, 16'hABCD, 4'd8,  1'b0, 16'hCDAB};
    vecs[9]  = '{1, 16'h8001, 4'd15, 1'b1, 16'hC000};
    vecs[10] = '{2, 16'h0003, 4'd15, 1'b0, 16'h0006};
    rst = 1; req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0; rsp_ready = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    // continuous round robin with a free-flowing consumer
    do_reset();
    req_valid = '1;
    req_amt = '0;
    req_dir = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 16'(16'h1111 * (i + 1));
    rsp_ready = 1;
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1) << (g % 4));
      @(posedge clk);
      @(negedge clk);
      chk("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
      chk("rr_rsp_data", 32'(rsp_data), 32'h1111 * 32'((g % 4) + 1));
      chk("rr_busy_ready", 32'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    // consumer stall: result holds and nothing is granted
    rsp_ready = 0;
    #1 chk("stall_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    held_data = rsp_data;
    held_id = rsp_id;
    chk("stall_id", 32'(held_id), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", 32'(rsp_data), 32'(held_data));
      chk("stall_id_hold", 32'(rsp_id), 32'(held_id));
      chk("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("hs_no_grant_valid", 32'(rsp_valid), 0);
    chk("hs_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    // skip ahead to the requester after the last grant
    do_reset();
    req_valid = 4'b0100;
    #1 chk("g2_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = 4'b1010;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("after2_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    // reset beats acceptance in IDLE
    rst = 1;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_beats_acc", 32'(rsp_valid), 0);
    rst = 0;
    // reset while holding a result discards it
    req_valid = 4'b1000;
    @(posedge clk);
    #1 req_valid = 4'b1010;
    @(negedge clk);
    chk("busy_before_rst", 32'(rsp_valid), 1);
    chk("busy_id_3", 32'(rsp_id), 3);
    rsp_ready = 1;
    do_reset();
    rsp_ready = 0;
    #1 chk("post_rst_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_id", 32'(rsp_id), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/barrel_shift_arb.md
BARREL_SHIFT_ARB -- requirements
Module: barrel_shift_arb

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; SHALL be a power of 2 and at least 4.
REQ-002 Parameter NREQ, default 4, number of requesters sharing the rotate datapath; SHALL be in the range 2 to 8.
REQ-003 Derived SW = $clog2(WIDTH), the rotate-amount width; derived IW = $clog2(NREQ), the requester-id width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NREQ  bit i set means requester i presents a request.
REQ-007 req_ready  output  NREQ  bit i set means requester i's request is accepted this cycle.
REQ-008 req_data  input  NREQ*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_amt  input  NREQ*SW  rotate amount of requester i at bits [i*SW +: SW].
REQ-010 req_dir  input  NREQ  bit i selects the direction for requester i: 0 = rotate right, 1 = rotate left.
REQ-011 rsp_valid  output  1  a result is presented.
REQ-012 rsp_ready  input  1  the consumer accepts the result.
REQ-013 rsp_data  output  WIDTH  the rotated result.
REQ-014 rsp_id  output  IW  index of the requester that owns rsp_data.

Function
REQ-015 The block SHALL implement two states: IDLE (no result held) and BUSY (result held, rsp_valid=1).
REQ-016 In IDLE, the block SHALL grant exactly one requester with req_valid set, chosen round-robin starting at pointer ptr and searching ptr, ptr+1, ... modulo NREQ.
REQ-017 req_ready SHALL be one-hot at the granted index in IDLE when any req_valid is set, and SHALL be all-zero otherwise, including in BUSY and during rst.
REQ-018 req_ready SHALL be a combinational function of req_valid, ptr and state; it SHALL NOT depend on req_data, req_amt or req_dir.
REQ-019 A request is accepted when req_valid[i] && req_ready[i].
REQ-020 On acceptance, the block SHALL register the rotation result and i, set rsp_valid next cycle (latency 1 cycle), move to BUSY, and set ptr = (i+1) mod NREQ.
REQ-021 Rotation SHALL be rotate-right by amt when dir=0, giving (d >> amt) | (d << (WIDTH-amt)) truncated to WIDTH bits.
REQ-022 Rotation SHALL be rotate-left by amt when dir=1, giving (d << amt) | (d >> (WIDTH-amt)) truncated to WIDTH bits.
REQ-023 amt=0 SHALL return d unchanged in both directions.
REQ-024 In BUSY, rsp_data and rsp_id SHALL hold stable while rsp_ready=0.
REQ-025 In BUSY, the state SHALL return to IDLE on the cycle after rsp_valid && rsp_ready, with rsp_valid=0 that next cycle.
REQ-026 No new request SHALL be accepted in the same cycle as a response handshake; peak throughput is one result per 2 cycles.
REQ-027 ptr SHALL change only on acceptance; requests that are valid but not granted SHALL leave ptr unchanged.
REQ-028 A requester that drops req_valid before being granted SHALL be ignored, with no state effect.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL enter IDLE and set ptr=0, rsp_valid=0, rsp_data=0 and rsp_id=0.
REQ-030 Reset asserted in BUSY SHALL discard the held result without a handshake.
REQ-031 Reset SHALL take priority over a simultaneous request acceptance or response handshake.

Verification
REQ-032 Scenario: WIDTH=16, requester 0 presents data 0xF04F, amt 5, dir 0 -> one cycle later rsp_valid=1, rsp_data=0x7F82, rsp_id=0.
REQ-033 Scenario: the same operand with dir=1 -> rsp_data=0x09FE; with amt=0 in either direction -> rsp_data=0xF04F.
REQ-034 Scenario: all 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one grant every 2 cycles, and rsp_id follows the same order.
REQ-035 Scenario: rsp_ready held 0 for 5 cycles while BUSY -> rsp_data and rsp_id stay constant, req_ready stays 0, and no grant occurs until 1 cycle after the handshake.
REQ-036 Scenario: after a grant to requester 2, only requesters 1 and 3 are valid -> requester 3 is granted next.
REQ-037 Scenario: rst pulsed while BUSY -> the next cycle shows rsp_valid=0 and ptr=0, and the first subsequent grant goes to the lowest-index valid requester.
